adxl345_seq_ctrl: RTL and testbench
===================================

// Module: adxl345_seq_ctrl
// PURPOSE
//   Transaction sequencer for the ADXL345 SPI master wrapper. After enable it writes DATA_FORMAT, then POWER_CTL (measure).
//   It then reads the axis registers at a fixed rate, asserting one command-select level and one start request per transaction.
//   Each returned word is captured with a valid pulse. Sits between top-level control and the SPI master wrapper; replaces manual switches.
// PARAMETERS
//   SAMPLE_DIV   100000  clk cycles between axis-read starts (>= 1 transaction length)
//   SETUP_CYC    4       cycles a select is held before spi_start (wrapper registers params + Byte_Command)
//   TIMEOUT_CYC  4096    max cycles waiting for spi_cs edge before error
//   DEVID_VAL    8'hE5   expected DEVID (used only with ADXL_DEVID_CHECK_EN)
// PORTS
//   clk            in   1   system clock
//   rst            in   1   async active-high reset
//   enable         in   1   level; 1 = run sequence, 0 = return to IDLE after current transaction
//   spi_cs         in   1   CS from SPI master; low = transaction in progress
//   spi_miso_data  in   16  parallel MISO data from SPI master
//   sel_format     out  1   select DATA_FORMAT write
//   sel_measure    out  1   select POWER_CTL measure write
//   sel_axis       out  1   select multi-byte axis read
//   sel_read       out  1   select single-byte DEVID read
//   spi_start      out  1   start request (drives master CS1)
//   sample         out  16  last captured axis word
//   sample_valid   out  1   1-cycle pulse, sample updated
//   busy           out  1   1 in any state other than IDLE/ERROR
//   err            out  1   sticky timeout/ID error; cleared only by rst or enable=0
//   state_dbg      out  4   current state encoding
// BEHAVIOUR
//   - Reset (async): state=IDLE. All sel_*, spi_start, sample_valid, busy, err = 0; sample = 0; counters = 0.
//   - Exactly one sel_* is high outside IDLE/ERROR/PERIOD; all are low in those states.
//   - Transaction sub-sequence per command, counted in cycles:
//     SETUP (sel high, SETUP_CYC cycles) -> START (spi_start=1 until spi_cs seen low) -> WAIT (spi_start=0, sel held until spi_cs rises) -> DONE (1 cycle).
//   - spi_cs sampled through 2-FF sync; edges detected on the synced value; adds 2 cycles of latency.
//   - Top FSM: IDLE -(enable)-> [ID] -> FMT -> PWR -> AXIS -> PERIOD -> AXIS ...
//   - PERIOD counter starts at AXIS START. The next AXIS starts at count SAMPLE_DIV-1; if the transaction is still running, it starts on its DONE instead (no overlap).
//   - AXIS DONE: sample <= spi_miso_data, sample_valid=1 same cycle as DONE + 1 register (latency 1 after synced cs rise).
//   - Timeout: counter reset on entering START/WAIT. Reaching TIMEOUT_CYC-1 -> ERROR: err=1, all sel_*/spi_start low.
//     Stays in ERROR until enable=0 -> IDLE (err cleared).
//   - enable falls mid-transaction: finish through DONE, then IDLE. Config is not redone unless enable re-rises.
//     Re-rise always restarts from FMT (or ID).
//   - enable falls in PERIOD: go to IDLE next cycle.
//   - rst mid-transaction: immediate IDLE; spi_start drops asynchronously.
//   - spi_cs already low when entering START (stale): treat as not-yet-started; wait for high then low (timeout applies).
//   - Counters sized $clog2(max param)+1; no wrap in PERIOD (saturating at SAMPLE_DIV-1).
// CONFIGURATION
//   ADXL_DEVID_CHECK_EN defined: ID state inserted before FMT.
//     - Runs a sel_read transaction, then compares spi_miso_data[7:0] to DEVID_VAL.
//     - Mismatch -> ERROR (err=1); match -> FMT.
//   Undefined: no ID state, sel_read tied 0, DEVID_VAL unused; IDLE -> FMT directly.
// TESTING
//   1 rst pulse mid-AXIS START -> all outputs 0 within same cycle, state_dbg=IDLE, no sample_valid.
//   2 enable=1, slave model drops spi_cs 10 cycles after start, raises 160 cycles later -> order sel_format, sel_measure, sel_axis; SETUP_CYC=4 gap each.
//   3 SAMPLE_DIV=500, axis reads return 16'h0123, 16'h0456 -> sample_valid pulses 500 cycles apart, sample matches.
//   4 Model never drops spi_cs -> err=1 after TIMEOUT_CYC cycles in START; enable=0 -> IDLE, err=0.
//   5 ADXL_DEVID_CHECK_EN, data 8'hE5 -> proceeds to FMT; data 8'hE4 -> ERROR, no sel_format.
//   6 enable=0 during AXIS WAIT -> DONE completes, sample_valid fires once, then IDLE; enable=1 again -> restarts at FMT.

Source files
------------

// File: rtl/adxl345_seq_ctrl.sv
// adxl345_seq_ctrl: transaction sequencer in front of the ADXL345 SPI master wrapper.
// After enable it writes DATA_FORMAT, then POWER_CTL (measure), then reads the axis
// registers every SAMPLE_DIV cycles. Each transaction raises one command select,
// holds it SETUP_CYC cycles, requests spi_start and follows spi_cs through to DONE.
// Optional feature macro: ADXL_DEVID_CHECK_EN inserts a DEVID read/compare before
// the DATA_FORMAT write.
module adxl345_seq_ctrl #(
  parameter int unsigned SAMPLE_DIV  = 100000,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [7:0]  DEVID_VAL   = 8'hE5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        spi_cs,
  input  logic [15:0] spi_miso_data,
  output logic        sel_format,
  output logic        sel_measure,
  output logic        sel_axis,
  output logic        sel_read,
  output logic        spi_start,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        err,
  output logic [3:0]  state_dbg
);

`ifdef ADXL_DEVID_CHECK_EN
  localparam logic ID_EN = 1'b1;
`else
  localparam logic ID_EN = 1'b0;
`endif

  localparam int unsigned MAX_A = (SAMPLE_DIV > TIMEOUT_CYC) ? SAMPLE_DIV : TIMEOUT_CYC;
  localparam int unsigned MAX_P = (MAX_A > SETUP_CYC) ? MAX_A : SETUP_CYC;
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] PER_LAST   = CW'(SAMPLE_DIV - 1);
  // Leave PERIOD early enough that the SETUP phase ends exactly at count
  // SAMPLE_DIV-1, so axis spi_start requests are SAMPLE_DIV cycles apart.
  localparam logic [CW-1:0] PER_GO     = CW'(SAMPLE_DIV - SETUP_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SETUP  = 4'd1,
    S_START  = 4'd2,
    S_WAIT   = 4'd3,
    S_DONE   = 4'd4,
    S_PERIOD = 4'd5,
    S_ERROR  = 4'd6
  } state_t;

  typedef enum logic [1:0] {
    CMD_ID   = 2'd0,
    CMD_FMT  = 2'd1,
    CMD_PWR  = 2'd2,
    CMD_AXIS = 2'd3
  } cmd_t;

  localparam cmd_t FIRST_CMD = ID_EN ? CMD_ID : CMD_FMT;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [CW-1:0] sub_cnt_q, sub_cnt_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic          cs_s1_q, cs_s2_q, cs_d_q;
  logic [15:0]   sample_q;
  logic          sample_valid_q;
  logic          cs_fall, cs_rise;
  logic          id_match;
  logic          in_txn;

  // Two-flop synchroniser for spi_cs plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1_q <= 1'b1;
      cs_s2_q <= 1'b1;
      cs_d_q  <= 1'b1;
    end else begin
      cs_s1_q <= spi_cs;
      cs_s2_q <= cs_s1_q;
      cs_d_q  <= cs_s2_q;
    end
  end

  // A stale low spi_cs on START entry produces no fall until it rises again.
  assign cs_fall  = cs_d_q & ~cs_s2_q;
  assign cs_rise  = ~cs_d_q & cs_s2_q;
  assign id_match = (spi_miso_data[7:0] == DEVID_VAL);

  // State, command and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= CMD_FMT;
      sub_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      sub_cnt_q <= sub_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  // Next-state logic: transaction sub-sequence interleaved with the command order.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    sub_cnt_d = sub_cnt_q;
    per_cnt_d = (per_cnt_q == PER_LAST) ? per_cnt_q : per_cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        sub_cnt_d = '0;
        if (enable) begin
          state_d = S_SETUP;
          cmd_d   = FIRST_CMD;
        end
      end
      S_SETUP: begin
        if (sub_cnt_q == SETUP_LAST) begin
          state_d   = S_START;
          sub_cnt_d = '0;
          if (cmd_q == CMD_AXIS) per_cnt_d = '0;
        end else begin
          sub_cnt_d = sub_cnt_q + CW'(1);
        end
      end
      S_START: begin
        if (cs_fall) begin
          state_d   = S_WAIT;
          sub_cnt_d = '0;
        end else if (sub_cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          sub_cnt_d = sub_cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cs_rise) begin
          state_d = S_DONE;
        end else if (sub_cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          sub_cnt_d = sub_cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        sub_cnt_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          case (cmd_q)
            CMD_ID: begin
              if (id_match) begin
                state_d = S_SETUP;
                cmd_d   = CMD_FMT;
              end else begin
                state_d = S_ERROR;
              end
            end
            CMD_FMT: begin
              state_d = S_SETUP;
              cmd_d   = CMD_PWR;
            end
            CMD_PWR: begin
              state_d = S_SETUP;
              cmd_d   = CMD_AXIS;
            end
            default: begin
              // An overrunning read starts the next one straight from DONE.
              state_d = (per_cnt_q >= PER_GO) ? S_SETUP : S_PERIOD;
            end
          endcase
        end
      end
      S_PERIOD: begin
        sub_cnt_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (per_cnt_q >= PER_GO) begin
          state_d = S_SETUP;
        end
      end
      S_ERROR: begin
        sub_cnt_d = '0;
        if (!enable) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Axis word capture: registered on DONE, valid pulse one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (state_q == S_DONE && cmd_q == CMD_AXIS) begin
        sample_q       <= spi_miso_data;
        sample_valid_q <= 1'b1;
      end
    end
  end

  // Output decode from the state register so reset clears them asynchronously.
  always_comb begin
    in_txn = (state_q == S_SETUP) || (state_q == S_START) ||
             (state_q == S_WAIT)  || (state_q == S_DONE);
  end

  assign sel_format   = in_txn && (cmd_q == CMD_FMT);
  assign sel_measure  = in_txn && (cmd_q == CMD_PWR);
  assign sel_axis     = in_txn && (cmd_q == CMD_AXIS);
  assign sel_read     = ID_EN && in_txn && (cmd_q == CMD_ID);
  assign spi_start    = (state_q == S_START);
  assign busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign err          = (state_q == S_ERROR);
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_adxl345_seq_ctrl.sv
// Scoreboard bench for adxl345_seq_ctrl: stimulus pushes the expected command
// order and axis words; a negedge monitor pops and compares on each spi_start
// request and each sample_valid pulse. A slave model answers spi_start.
module tb_adxl345_seq_ctrl;

  localparam int SDIV = 500;
  localparam int SCYC = 4;
  localparam int TMO  = 256;

  localparam logic [3:0] S_FMT  = 4'b0001;
  localparam logic [3:0] S_PWR  = 4'b0010;
  localparam logic [3:0] S_AXIS = 4'b0100;
  localparam logic [3:0] S_READ = 4'b1000;

  logic        clk, rst, enable, spi_cs;
  logic [15:0] spi_miso_data;
  logic        sel_format, sel_measure, sel_axis, sel_read, spi_start;
  logic [15:0] sample;
  logic        sample_valid, busy, err;
  logic [3:0]  state_dbg;

  adxl345_seq_ctrl #(
    .SAMPLE_DIV (SDIV),
    .SETUP_CYC  (SCYC),
    .TIMEOUT_CYC(TMO),
    .DEVID_VAL  (8'hE5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi_cs       (spi_cs),
    .spi_miso_data(spi_miso_data),
    .sel_format   (sel_format),
    .sel_measure  (sel_measure),
    .sel_axis     (sel_axis),
    .sel_read     (sel_read),
    .spi_start    (spi_start),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  typedef struct {
    logic [3:0] sel;
    int         gap;
  } exp_cmd_t;

  exp_cmd_t    exp_cmd[$];
  logic [15:0] exp_smp[$];
  logic [15:0] slave_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0;
  logic slave_mute = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event within cycle budget, required event", name);
  endtask

  function automatic int sel_vec();
    return int'({sel_read, sel_axis, sel_measure, sel_format});
  endfunction

  // Slave: drop cs 10 cycles after a start request, raise it 160 later with data.
  initial begin
    spi_cs = 1'b1;
    spi_miso_data = '0;
    forever begin
      @(negedge clk);
      if (spi_start && !slave_mute && !rst) begin
        repeat (10) @(negedge clk);
        spi_cs = 1'b0;
        repeat (160) @(negedge clk);
        spi_miso_data = (slave_q.size() > 0) ? slave_q.pop_front() : 16'h0000;
        spi_cs = 1'b1;
      end
    end
  end

  // Monitor: compares each start request and each sample against the queues.
  initial begin
    logic     prev_start;
    int       prev_sel;
    int       setup_cnt;
    int       last_axis;
    exp_cmd_t c;
    int       sv;
    prev_start = 1'b0;
    prev_sel   = 0;
    setup_cnt  = 0;
    last_axis  = 0;
    forever begin
      @(negedge clk);
      sv = sel_vec();
      if (spi_start && !prev_start) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got sel=%b required no request", sv[3:0]);
        end else begin
          c = exp_cmd.pop_front();
          check("start_sel", sv, int'(c.sel));
          check("setup_cycles", setup_cnt, SCYC);
          if (c.gap > 0) check("axis_period", cyc - last_axis, c.gap);
        end
        if (sv == int'(S_AXIS)) last_axis = cyc;
      end
      if (sample_valid) begin
        n_valid++;
        if (exp_smp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got sample=0x%0h required no pulse", sample);
        end else begin
          check("sample", int'(sample), int'(exp_smp.pop_front()));
        end
      end
      if (spi_start || sv != prev_sel || sv == 0)
        setup_cnt = (sv != 0 && !spi_start) ? 1 : 0;
      else
        setup_cnt++;
      prev_start = spi_start;
      prev_sel   = sv;
    end
  end

  task automatic push_cmd(input logic [3:0] sel, input int gap);
    exp_cmd_t c;
    c.sel = sel;
    c.gap = gap;
    exp_cmd.push_back(c);
  endtask

  task automatic push_config();
`ifdef ADXL_DEVID_CHECK_EN
    push_cmd(S_READ, 0);
    slave_q.push_back({8'($urandom), 8'hE5});
`endif
    push_cmd(S_FMT, 0);
    slave_q.push_back(16'h0000);
    push_cmd(S_PWR, 0);
    slave_q.push_back(16'h0000);
  endtask

  task automatic push_axis(input int gap, input logic expect_valid);
    logic [15:0] r;
    r = 16'($urandom);
    push_cmd(S_AXIS, gap);
    slave_q.push_back(r);
    if (expect_valid) exp_smp.push_back(r);
  endtask

  task automatic wait_axis_start(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (spi_start && sel_axis) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss("wait_axis_start");
  endtask

  task automatic wait_valid(input int n, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_valid >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss("wait_sample_valid");
  endtask

  task automatic wait_err(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (err) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) miss("wait_err");
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_sel"}, sel_vec(), 0);
    check({tag, "_spi_start"}, int'(spi_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic ok;
    int   t0;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_all_low("reset");
    check("reset_err", int'(err), 0);
    check("reset_sample", int'(sample), 0);
    check("reset_valid", int'(sample_valid), 0);
    rst = 1'b0;

    // Reset pulse during an axis START: outputs clear before the next edge.
    push_config();
    push_axis(0, 1'b0);
    enable = 1'b1;
    wait_axis_start(1500, ok);
    if (ok) begin
      #2 rst = 1'b1;
      #1;
      check_all_low("async_rst");
      check("async_rst_valid", int'(sample_valid), 0);
      check("async_rst_err", int'(err), 0);
    end
    @(negedge clk);
    enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    check("idle_after_rst", int'(busy), 0);

    // Configuration order, then three axis reads at SAMPLE_DIV spacing.
    push_config();
    push_axis(0, 1'b1);
    push_axis(SDIV, 1'b1);
    push_axis(SDIV, 1'b1);
    enable = 1'b1;
    wait_valid(3, 4000);

    // enable drops while the fourth read is in WAIT: it completes, then IDLE.
    push_axis(SDIV, 1'b1);
    wait_axis_start(600, ok);
    repeat (40) @(negedge clk);
    check("mid_wait_spi_start", int'(spi_start), 0);
    check("mid_wait_busy", int'(busy), 1);
    enable = 1'b0;
    wait_valid(4, 300);
    repeat (3) @(negedge clk);
    check("disable_idle", int'(busy), 0);
    repeat (600) @(negedge clk);
    check("disable_stays_idle", int'(busy), 0);

    // Re-enable restarts the configuration writes.
    push_config();
    push_axis(0, 1'b1);
    enable = 1'b1;
    wait_valid(5, 1500);

    // Silent slave: START times out into ERROR.
    slave_mute = 1'b1;
    push_cmd(S_AXIS, SDIV);
    wait_axis_start(600, ok);
    t0 = cyc;
    wait_err(TMO + 20);
    check("timeout_latency", cyc - t0, TMO);
    check("error_sel", sel_vec(), 0);
    check("error_spi_start", int'(spi_start), 0);
    check("error_busy", int'(busy), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("error_cleared", int'(err), 0);
    check("error_idle_busy", int'(busy), 0);
    slave_mute = 1'b0;

`ifdef ADXL_DEVID_CHECK_EN
    // Wrong DEVID: read transaction then ERROR, no DATA_FORMAT write.
    push_cmd(S_READ, 0);
    slave_q.push_back(16'h00E4);
    enable = 1'b1;
    wait_err(800);
    check("devid_err_sel", sel_vec(), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("devid_err_cleared", int'(err), 0);
`endif

    repeat (20) @(negedge clk);
    check("leftover_cmds", exp_cmd.size(), 0);
    check("leftover_samples", exp_smp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
